stack64_ctrl: RTL and testbench

LIFO stack controller that sits directly upstream of the 64-entry RAM64 and drives its `load`/`address`/`in` ports, consuming its `out`. It turns push/pop requests into single-cycle RAM writes and reads. It maintains a stack pointer, full/empty status and sticky overflow/underflow flags. It also offers a sweep operation that zero-fills all 64 words.

---
 rtl/stack64_ctrl_pkg.sv | 32 +++
 rtl/stack64_ctrl_if.sv | 28 ++
 rtl/stack64_ctrl_sweep_counter6.sv | 25 ++
 rtl/stack64_ctrl.sv | 131 +++++++++++++
 tb/tb_stack64_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/stack64_ctrl_pkg.sv
// Shared constants, FSM state type and request decoding for the LIFO stack controller.
package stack64_ctrl_pkg;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // What a push/pop request pair resolves to, given the current fill level.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_PUSH_FULL,
        OP_POP,
        OP_POP_EMPTY,
        OP_SWAP,
        OP_PUSH_POP_EMPTY
    } op_t;

    function automatic op_t decode_op(input logic push, input logic pop,
                                      input logic full, input logic empty);
        if (push && pop) return empty ? OP_PUSH_POP_EMPTY : OP_SWAP;
        if (push)        return full  ? OP_PUSH_FULL      : OP_PUSH;
        if (pop)         return empty ? OP_POP_EMPTY      : OP_POP;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/stack64_ctrl_if.sv
// Request/status bundle between a stack user (master) and the stack controller (slave).
interface stack64_ctrl_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 6
);
    logic              push;
    logic              pop;
    logic              clear;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              valid_out;
    logic [ADDR_W:0]   sp;
    logic              full;
    logic              empty;
    logic              busy;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, clear, data_in,
        input  data_out, valid_out, sp, full, empty, busy, overflow, underflow
    );

    modport slave (
        input  push, pop, clear, data_in,
        output data_out, valid_out, sp, full, empty, busy, overflow, underflow
    );
endinterface

// File: rtl/stack64_ctrl_sweep_counter6.sv
// Up-counter providing the RAM address during a zero-fill sweep.
module sweep_counter6 #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_cnt;

    // Count register: synchronous restart has priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_cnt <= '0;
        else if (i_start) r_cnt <= '0;
        else if (i_en)    r_cnt <= r_cnt + CNT_ONE;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = &r_cnt;
endmodule

// File: rtl/stack64_ctrl.sv
// LIFO stack controller driving a 64-word RAM with combinational read.
module stack64_ctrl
    import stack64_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned ADDR_W = stack64_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    stack64_ctrl_if.slave     bus,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WIDTH-1:0]  mem_in,
    input  logic [WIDTH-1:0]  mem_out
);
    localparam logic [ADDR_W:0]   SP_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

    state_t            r_state, w_next;
    logic [ADDR_W:0]   r_sp;
    logic [WIDTH-1:0]  r_dout;
    logic              r_valid, r_ovf, r_unf;
    logic              w_full, w_empty, w_idle_req, w_start, w_tc, w_sweep;
    logic [ADDR_W-1:0] w_cnt, w_top_addr;
    op_t               w_op;

    assign w_full     = (r_sp == SP_FULL);
    assign w_empty    = (r_sp == '0);
    // Wraps correctly at sp=64: low bits are 0, so top lands on 63.
    assign w_top_addr = r_sp[ADDR_W-1:0] - A_ONE;
    assign w_op       = decode_op(bus.push, bus.pop, w_full, w_empty);
    assign w_sweep    = (r_state == ST_SWEEP);
    assign w_start    = (r_state == ST_IDLE) && bus.clear;
    assign w_idle_req = (r_state == ST_IDLE) && !bus.clear;

    sweep_counter6 #(.W(ADDR_W)) u_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_start),
        .i_en    (w_sweep),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state: clear starts a sweep, terminal count ends it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clear) w_next = ST_SWEEP;
            ST_SWEEP: if (w_tc)      w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: RAM port drive and busy.
    always_comb begin
        mem_load    = 1'b0;
        mem_address = r_sp[ADDR_W-1:0];
        mem_in      = bus.data_in;
        bus.busy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.pop && !w_empty) mem_address = w_top_addr;
                if (!bus.clear && (w_op == OP_PUSH || w_op == OP_SWAP || w_op == OP_PUSH_POP_EMPTY))
                    mem_load = 1'b1;
            end
            ST_SWEEP: begin
                mem_load    = 1'b1;
                mem_address = w_cnt;
                mem_in      = '0;
                bus.busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // Stack pointer, popped data and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp    <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (w_sweep && w_tc) begin
                r_sp <= '0;
            end else if (w_idle_req) begin
                case (w_op)
                    OP_PUSH:           r_sp <= r_sp + SP_ONE;
                    OP_PUSH_FULL:      r_ovf <= 1'b1;
                    OP_POP: begin
                        r_sp    <= r_sp - SP_ONE;
                        r_dout  <= mem_out;
                        r_valid <= 1'b1;
                    end
                    OP_POP_EMPTY:      r_unf <= 1'b1;
                    OP_SWAP: begin
                        r_dout  <= mem_out;
                        r_valid <= 1'b1;
                    end
                    OP_PUSH_POP_EMPTY: begin
                        r_sp  <= r_sp + SP_ONE;
                        r_unf <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sp        = r_sp;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.data_out  = r_dout;
    assign bus.valid_out = r_valid;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
endmodule

// File: tb/tb_stack64_ctrl.sv
// Randomized and directed bench for stack64_ctrl against a queue-based LIFO model.
module tb_stack64_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_load;
    logic [5:0]  mem_address;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic [15:0] ram [64] = '{default: '0};

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    logic [15:0] stk [$];
    logic        m_ovf, m_unf, m_valid;
    logic [15:0] m_dout;
    int          m_sweep_left;

    stack64_ctrl_if #(.WIDTH(16), .ADDR_W(6)) bus_if ();

    stack64_ctrl #(.WIDTH(16), .ADDR_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .mem_load    (mem_load),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_out     (mem_out)
    );

    always #5 clk = ~clk;

    // RAM64 stand-in: synchronous write, combinational read.
    always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
    assign mem_out = ram[mem_address];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 0; m_unf = 0; m_valid = 0; m_dout = '0; m_sweep_left = 0;
    endtask

    task automatic model_edge(input logic p, input logic q, input logic c, input logic [15:0] d);
        m_valid = 0;
        if (m_sweep_left > 0) begin
            m_sweep_left--;
            if (m_sweep_left == 0) stk.delete();
        end else if (c) begin
            m_sweep_left = 64;
            m_ovf = 0;
            m_unf = 0;
        end else if (p && q) begin
            if (stk.size() > 0) begin
                m_dout = stk.pop_back();
                stk.push_back(d);
                m_valid = 1;
            end else begin
                stk.push_back(d);
                m_unf = 1;
            end
        end else if (p) begin
            if (stk.size() == 64) m_ovf = 1;
            else stk.push_back(d);
        end else if (q) begin
            if (stk.size() == 0) m_unf = 1;
            else begin
                m_dout = stk.pop_back();
                m_valid = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sp"},    32'(bus_if.sp),        32'(stk.size()));
        check({tag, ".full"},  32'(bus_if.full),      32'(stk.size() == 64));
        check({tag, ".empty"}, 32'(bus_if.empty),     32'(stk.size() == 0));
        check({tag, ".busy"},  32'(bus_if.busy),      32'(m_sweep_left > 0));
        check({tag, ".ovf"},   32'(bus_if.overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(bus_if.underflow), 32'(m_unf));
        check({tag, ".valid"}, 32'(bus_if.valid_out), 32'(m_valid));
        check({tag, ".dout"},  32'(bus_if.data_out),  32'(m_dout));
    endtask

    task automatic step(input string tag, input logic p, input logic q, input logic c, input logic [15:0] d);
        bus_if.push = p; bus_if.pop = q; bus_if.clear = c; bus_if.data_in = d;
        @(posedge clk);
        model_edge(p, q, c, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.push = 0; bus_if.pop = 0; bus_if.clear = 0; bus_if.data_in = '0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("rst");
        check("rst.mem_load", 32'(mem_load), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nb, bad;
        model_reset();
        do_reset();

        // Pop on empty: sticky underflow survives later pushes
        step("pop_empty", 0, 1, 0, 16'h1234);
        check("pop_empty.unf", 32'(bus_if.underflow), 32'd1);
        check("pop_empty.dout", 32'(bus_if.data_out), 32'd0);
        step("push_after_unf", 1, 0, 0, 16'h0042);
        step("push_after_unf2", 1, 0, 0, 16'h0043);
        check("unf_sticky", 32'(bus_if.underflow), 32'd1);

        // Push 1..3 then pop three times
        do_reset();
        for (int i = 1; i <= 3; i++) step("push123", 1, 0, 0, 16'(i));
        check("sp3", 32'(bus_if.sp), 32'd3);
        for (int i = 3; i >= 1; i--) begin
            step("pop321", 0, 1, 0, 16'h0);
            check("pop321.val", 32'(bus_if.data_out), 32'(i));
        end
        step("after_pops", 0, 0, 0, 16'h0);
        check("after_pops.valid", 32'(bus_if.valid_out), 32'd0);
        check("after_pops.empty", 32'(bus_if.empty), 32'd1);

        // Fill to full, then one refused push
        do_reset();
        for (int i = 0; i < 64; i++) step("fill", 1, 0, 0, 16'(i));
        check("full64", 32'(bus_if.full), 32'd1);
        step("push65", 1, 0, 0, 16'hDEAD);
        check("push65.ovf", 32'(bus_if.overflow), 32'd1);
        check("push65.sp", 32'(bus_if.sp), 32'd64);
        check("ram63", 32'(ram[63]), 32'h003F);

        // Swap-top
        do_reset();
        step("swap_setup", 1, 0, 0, 16'hAAAA);
        step("swap_setup", 1, 0, 0, 16'hBBBB);
        step("swap", 1, 1, 0, 16'hCCCC);
        check("swap.dout", 32'(bus_if.data_out), 32'hBBBB);
        check("swap.sp", 32'(bus_if.sp), 32'd2);
        step("swap_pop", 0, 1, 0, 16'h0);
        check("swap_pop.dout", 32'(bus_if.data_out), 32'hCCCC);

        // Sweep: flags cleared, exactly 64 busy cycles, requests ignored
        do_reset();
        step("pre_unf", 0, 1, 0, 16'h0);
        for (int i = 0; i < 10; i++) step("fill10", 1, 0, 0, 16'(16'h0500 + i));
        step("clear", 0, 0, 1, 16'h0);
        nb = bus_if.busy ? 1 : 0;
        for (int g = 0; g < 100 && bus_if.busy; g++) begin
            step("sweep", 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            if (bus_if.busy) nb++;
        end
        check("busy_len", nb, 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] != 16'h0) bad++;
        check("ram_zeroed", bad, 32'd0);
        step("post_sweep_push", 1, 0, 0, 16'h7777);
        check("post_sweep_push.sp", 32'(bus_if.sp), 32'd1);

        // Reset during sweep cycle 20
        do_reset();
        for (int i = 0; i < 64; i++) step("fill_b", 1, 0, 0, 16'(16'h0100 + i));
        step("clear_b", 0, 0, 1, 16'h0);
        for (int i = 0; i < 20; i++) step("sweep_b", 0, 0, 0, 16'h0);
        reset = 1'b1;
        #1;
        check("midrst.busy", 32'(bus_if.busy), 32'd0);
        check("midrst.sp", 32'(bus_if.sp), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (ram[i] != ((i < 20) ? 16'h0 : 16'(16'h0100 + i))) bad++;
        check("midrst.ram", bad, 32'd0);
        check_all("midrst");

        // Randomized traffic with phases biased toward filling or draining
        for (int i = 0; i < 3000; i++) begin
            int unsigned pp = ((i / 150) % 2 == 0) ? 70 : 30;
            step("rand", 1'($urandom_range(0, 99) < pp), 1'($urandom_range(0, 99) < (100 - pp)),
                 1'($urandom_range(0, 299) == 0), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
